// File: rtl/btn_hold_detector_pkg.sv
// Shared types and helpers for the multi-channel button hold detector.
package btn_hold_detector_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DEB_PRESS = 3'd1,
        ST_PRESSED   = 3'd2,
        ST_LONG_HELD = 3'd3,
        ST_DEB_REL   = 3'd4
    } btn_state_t;

    // Map a raw pin to "1 = pressed" regardless of board wiring.
    function automatic logic norm_polarity(input logic raw, input logic active_high);
        return raw ^ ~active_high;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-FF synchroniser, debounce/hold FSM, tick-based counters.
module btn_channel
    import btn_hold_detector_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 20,
    parameter int LONG_TICKS     = 5000,
    parameter int ACTIVE_HIGH    = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_btn,
    output logic o_level,
    output logic o_short,
    output logic o_long,
    output logic o_hold
);

    localparam int DEB_W  = $clog2(DEBOUNCE_TICKS + 1);
    localparam int HOLD_W = $clog2(LONG_TICKS + 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS);

    btn_state_t        r_state, w_state;
    logic              r_sync_meta, r_sync;
    logic [DEB_W-1:0]  r_deb_cnt, w_deb_cnt, w_deb_inc;
    logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt, w_hold_inc;
    logic              r_was_long, w_was_long;
    logic              r_level, w_level;
    logic              r_hold, w_hold;
    logic              r_short, w_short;
    logic              r_long, w_long;

    assign w_deb_inc  = r_deb_cnt + DEB_W'(1);
    assign w_hold_inc = r_hold_cnt + HOLD_W'(1);

    // NOTE: state is updated only with non-blocking assignments so every register
    // samples the pre-edge values; the async reset clears all of it, synchroniser included.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync_meta <= 1'b0;
            r_sync      <= 1'b0;
            r_state     <= ST_IDLE;
            r_deb_cnt   <= '0;
            r_hold_cnt  <= '0;
            r_was_long  <= 1'b0;
            r_level     <= 1'b0;
            r_hold      <= 1'b0;
            r_short     <= 1'b0;
            r_long      <= 1'b0;
        end else begin
            r_sync_meta <= norm_polarity(i_btn, ACTIVE_HIGH != 0);
            r_sync      <= r_sync_meta;
            r_state     <= w_state;
            r_deb_cnt   <= w_deb_cnt;
            r_hold_cnt  <= w_hold_cnt;
            r_was_long  <= w_was_long;
            r_level     <= w_level;
            r_hold      <= w_hold;
            r_short     <= w_short;
            r_long      <= w_long;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state    = r_state;
        w_deb_cnt  = r_deb_cnt;
        w_hold_cnt = r_hold_cnt;
        w_was_long = r_was_long;
        w_level    = r_level;
        w_hold     = r_hold;
        w_short    = 1'b0;
        w_long     = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (r_sync) begin
                    w_deb_cnt = '0;
                    w_state   = ST_DEB_PRESS;
                end
            end
            ST_DEB_PRESS: begin
                if (!r_sync) begin
                    w_deb_cnt = '0;
                    w_state   = ST_IDLE;
                end else if (i_tick) begin
                    if (w_deb_inc == DEB_LAST) begin
                        w_deb_cnt  = '0;
                        w_hold_cnt = '0;
                        w_level    = 1'b1;
                        w_state    = ST_PRESSED;
                    end else begin
                        w_deb_cnt = w_deb_inc;
                    end
                end
            end
            ST_PRESSED: begin
                // Input change wins over a coincident tick.
                if (!r_sync) begin
                    w_deb_cnt  = '0;
                    w_was_long = 1'b0;
                    w_state    = ST_DEB_REL;
                end else if (i_tick) begin
                    w_hold_cnt = w_hold_inc;
                    if (w_hold_inc == HOLD_LAST) begin
                        w_long  = 1'b1;
                        w_hold  = 1'b1;
                        w_state = ST_LONG_HELD;
                    end
                end
            end
            ST_LONG_HELD: begin
                if (!r_sync) begin
                    w_deb_cnt  = '0;
                    w_was_long = 1'b1;
                    w_state    = ST_DEB_REL;
                end
            end
            ST_DEB_REL: begin
                if (r_sync) begin
                    w_state = r_was_long ? ST_LONG_HELD : ST_PRESSED;
                end else if (i_tick) begin
                    if (w_deb_inc == DEB_LAST) begin
                        w_deb_cnt = '0;
                        w_level   = 1'b0;
                        w_hold    = 1'b0;
                        w_short   = ~r_was_long;
                        w_state   = ST_IDLE;
                    end else begin
                        w_deb_cnt = w_deb_inc;
                    end
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    assign o_level = r_level;
    assign o_short = r_short;
    assign o_long  = r_long;
    assign o_hold  = r_hold;

endmodule

// File: rtl/btn_hold_detector.sv
// N-channel button debounce and short/long press classifier sharing one tick prescaler.
module btn_hold_detector
    import btn_hold_detector_pkg::*;
#(
    parameter int N_BTN          = 4,
    parameter int TICK_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int LONG_TICKS     = 5000,
    parameter int ACTIVE_HIGH    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] short_pulse,
    output logic [N_BTN-1:0] long_pulse,
    output logic [N_BTN-1:0] hold_active
);

    localparam int PRESC_W = $clog2(TICK_DIV);

    logic [PRESC_W-1:0] r_presc;
    logic               w_tick;

    assign w_tick = (r_presc == PRESC_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .LONG_TICKS     (LONG_TICKS),
            .ACTIVE_HIGH    (ACTIVE_HIGH)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .i_tick  (w_tick),
            .i_btn   (btn_in[g]),
            .o_level (btn_level[g]),
            .o_short (short_pulse[g]),
            .o_long  (long_pulse[g]),
            .o_hold  (hold_active[g])
        );
    end

endmodule
